// File: rtl/mem_line_requester_if.sv
// Cache-side request port plus the main-memory VALID/READY/LOAD/STORE/ACK bus.
// master = the line requester, slave = the cache controller and memory responder side.
interface mem_line_requester_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        line_we;
    logic [2:0]  line_idx;
    logic [31:0] line_data;
    logic        done;
    logic        err;
    logic        valid;
    logic        load;
    logic        store;
    logic        ready;
    logic [31:0] mem_wdata;
    logic        ack_addr;
    logic [31:0] mem_rdata;
    logic [3:0]  ack_data_in;
    logic [3:0]  ack_data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, ready, mem_rdata, ack_data_in,
        output req_ready, line_we, line_idx, line_data, done, err,
               valid, load, store, mem_wdata, ack_addr, ack_data_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, ready, mem_rdata, ack_data_in,
        input  req_ready, line_we, line_idx, line_data, done, err,
               valid, load, store, mem_wdata, ack_addr, ack_data_out
    );
endinterface

// File: rtl/mem_line_requester.sv
// Turns one cache miss (line refill) or word store into a main-memory bus transaction.
// Latency: best case one refill word per two cycles; backpressure: req_ready low until DONE/ERR.
module mem_line_requester #(
    parameter int LINE_WORDS     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_line_requester_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, RX, TX, FIN} state_t;

    localparam int          CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LOAD_MASK = ~32'(LINE_WORDS * 4 - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(LINE_WORDS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    k_q;
    logic          line_we_q;
    logic [2:0]    line_idx_q;
    logic [31:0]   line_data_q;
    logic [3:0]    ack_out_q;
    logic          done_q;
    logic          err_q;
    logic          capture;
    logic          timeout;
    logic          bus_active;

    assign bus.line_we      = line_we_q;
    assign bus.line_idx     = line_idx_q;
    assign bus.line_data    = line_data_q;
    assign bus.ack_data_out = ack_out_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

    always_comb begin
        state_nxt     = state;
        capture       = 1'b0;
        timeout       = 1'b0;
        bus.req_ready = 1'b0;
        bus.mem_wdata = '0;
        bus.ack_addr  = 1'b0;
        bus_active    = (state == REQ) || (state == ADDR) || (state == RX) || (state == TX);
        bus.valid     = bus_active;
        bus.load      = bus_active && !wr_q;
        bus.store     = bus_active && wr_q;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = REQ;
            end
            REQ: begin
                if (bus.ready) state_nxt = ADDR;
            end
            ADDR: begin
                bus.mem_wdata = addr_q;
                bus.ack_addr  = 1'b1;
                if (bus.ack_data_in == 4'd0) state_nxt = wr_q ? TX : RX;
            end
            RX: begin
                // The cycle after a capture is the echo cycle; no new word is taken then.
                if (line_we_q && line_idx_q == LAST_IDX) begin
                    state_nxt = FIN;
                end else if (!line_we_q && bus.ack_data_in == {1'b0, k_q}) begin
                    capture = 1'b1;
                end
            end
            TX: begin
                bus.mem_wdata = wdata_q;
                if (bus.ack_data_in == 4'd1) state_nxt = FIN;
            end
            FIN: begin
                if (!bus.ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE && state_nxt == state && !capture && tmo_cnt == TMO_LAST) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            k_q         <= '0;
            line_we_q   <= 1'b0;
            line_idx_q  <= '0;
            line_data_q <= '0;
            ack_out_q   <= 4'b1000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state || capture) begin
                tmo_cnt <= '0;
            end else if (state != IDLE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == IDLE && bus.req_valid) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_write ? (bus.req_addr & ~32'd3) : (bus.req_addr & LOAD_MASK);
                wdata_q <= bus.req_wdata;
            end

            if (state == ADDR) begin
                k_q <= '0;
            end else if (capture) begin
                k_q <= k_q + 1'b1;
            end

            line_we_q <= capture;
            ack_out_q <= capture ? {1'b0, k_q} : 4'b1000;
            if (capture) begin
                line_idx_q  <= k_q;
                line_data_q <= bus.mem_rdata;
            end

            done_q <= (state == FIN) && (state_nxt == IDLE) && !timeout;
            err_q  <= timeout;
        end
    end
endmodule
